fetch_ctrl: RTL and testbench

Instruction-fetch sequencer sitting directly around the program-counter register. It commands the PC register to read out (re_PC), captures the returned address, and issues a memory read. It latches the fetched word into an instruction register and hands it downstream with a valid/ready handshake. It then computes the next PC (sequential or branch) and writes it back via wr_PC.

---
 rtl/fetch_ctrl_pkg.sv | 22 ++
 rtl/fetch_timeout_cnt.sv | 30 +++
 rtl/fetch_ctrl.sv | 119 +++++++++++
 tb/tb_fetch_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the fetch sequencer: state encoding, default widths
// (common with the PC register) and the timeout counter width.
package fetch_ctrl_pkg;
  localparam int ADDR_W_DEF = 18;
  localparam int DATA_W_DEF = 16;
  localparam int CNT_W      = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_CAP   = 3'd2,
    S_REQ   = 3'd3,
    S_ISSUE = 3'd4,
    S_WR    = 3'd5,
    S_FAULT = 3'd6
  } fetch_state_e;

  // Count value seen on the TIMEOUT-th wait cycle (count starts at 0).
  function automatic logic [CNT_W-1:0] term_val(input int timeout);
    return CNT_W'(timeout - 1);
  endfunction
endpackage

// File: rtl/fetch_timeout_cnt.sv
// Loadable up-counter with clear/enable; term_o flags the last allowed wait cycle.
module fetch_timeout_cnt
  import fetch_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             ld_i,
  input  logic [CNT_W-1:0] ld_val_i,
  output logic             term_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (ld_i) cnt_d = ld_val_i;
    else if (en_i) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign term_o = (cnt_q == term_val(TIMEOUT));
endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: reads the PC register, fetches from memory,
// hands the word downstream with valid/ready and writes back the next PC.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic              re_PC,
  output logic              wr_PC,
  input  logic [ADDR_W-1:0] PC_cur,
  output logic [ADDR_W-1:0] PC_next,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              fault
);
  fetch_state_e      state_q;
  logic              re_pc_q, wr_pc_q, mem_rd_q, instr_valid_q, fault_q;
  logic [ADDR_W-1:0] pc_next_q, fetch_addr_q, instr_pc_q;
  logic [DATA_W-1:0] instr_q;
  logic              in_req, to_term;

  assign in_req = (state_q == S_REQ);

  // Counter is re-armed on CAP so every fetch gets a full TIMEOUT window.
  fetch_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (in_req && mem_ack),
    .en_i    (in_req && !mem_ack),
    .ld_i    (state_q == S_CAP),
    .ld_val_i('0),
    .term_o  (to_term)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      re_pc_q       <= 1'b0;
      wr_pc_q       <= 1'b0;
      mem_rd_q      <= 1'b0;
      instr_valid_q <= 1'b0;
      fault_q       <= 1'b0;
      pc_next_q     <= '0;
      fetch_addr_q  <= '0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (run) begin
          state_q <= S_RD;
          re_pc_q <= 1'b1;
        end
        S_RD: begin
          state_q <= S_CAP;
          re_pc_q <= 1'b0;
        end
        S_CAP: begin
          state_q      <= S_REQ;
          fetch_addr_q <= PC_cur;
          mem_rd_q     <= 1'b1;
        end
        S_REQ: begin
          // Ack wins over a simultaneous timeout.
          if (mem_ack) begin
            state_q       <= S_ISSUE;
            mem_rd_q      <= 1'b0;
            instr_q       <= mem_rdata;
            instr_pc_q    <= fetch_addr_q;
            instr_valid_q <= 1'b1;
          end else if (to_term) begin
            state_q  <= S_FAULT;
            mem_rd_q <= 1'b0;
            fault_q  <= 1'b1;
          end
        end
        S_ISSUE: if (instr_ready) begin
          state_q       <= S_WR;
          pc_next_q     <= br_taken ? br_target : fetch_addr_q + ADDR_W'(1);
          instr_valid_q <= 1'b0;
          wr_pc_q       <= 1'b1;
        end
        S_WR: begin
          wr_pc_q <= 1'b0;
          if (run) begin
            state_q <= S_RD;
            re_pc_q <= 1'b1;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_FAULT: state_q <= S_FAULT;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign re_PC       = re_pc_q;
  assign wr_PC       = wr_pc_q;
  assign PC_next     = pc_next_q;
  assign mem_rd      = mem_rd_q;
  assign mem_addr    = fetch_addr_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign fault       = fault_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: PC register + memory models, scoreboard monitor,
// vector table for single fetches and hand sequences for multi-cycle cases.
module tb_fetch_ctrl;
  localparam int AW = 18;
  localparam int DW = 16;
  localparam int TO = 15;

  logic clk = 0, rst = 1, run = 0;
  logic re_PC, wr_PC, mem_rd, mem_ack, br_taken, instr_valid, instr_ready, fault;
  logic [AW-1:0] PC_cur, PC_next, mem_addr, br_target, instr_pc;
  logic [DW-1:0] mem_rdata, instr;

  always #5 clk = ~clk;

  fetch_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .run(run), .re_PC(re_PC), .wr_PC(wr_PC),
    .PC_cur(PC_cur), .PC_next(PC_next), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .br_taken(br_taken),
    .br_target(br_target), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .fault(fault)
  );

  // Environment models
  logic [AW-1:0] pc_reg, pc_rst_val = '0;
  logic          pc_oe;
  int            req_cyc, ack_dly = 0, cyc = 0;
  bit            ack_en = 1, ack_force = 0, rdy = 1, br_iss = 0, br_req = 0;
  logic [AW-1:0] tgt = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) pc_reg <= pc_rst_val;
    else if (wr_PC) pc_reg <= PC_next;
    pc_oe   <= re_PC && !rst;
    req_cyc <= mem_rd ? req_cyc + 1 : 0;
  end

  assign PC_cur      = pc_oe ? pc_reg : 18'h2AAAA;
  assign mem_ack     = (mem_rd && ack_en && req_cyc >= ack_dly) || ack_force;
  assign mem_rdata   = mem_addr[15:0] ^ 16'hA001;
  assign instr_ready = rdy;
  assign br_taken    = (br_iss && instr_valid) || (br_req && mem_rd);
  assign br_target   = tgt;

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // Scoreboard: expectation pushed when a fetch starts, compared at handshake / write-back.
  typedef struct { logic [AW-1:0] pc; logic [DW-1:0] data; logic [AW-1:0] nxt; } exp_t;
  exp_t sbq[$];
  exp_t e;
  bit prev_v = 0, prev_hs = 0;
  logic [DW-1:0] prev_instr;

  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
      prev_v = 0;
    end else begin
      chk("strobe_overlap", {re_PC, wr_PC} == 2'b11, 0);
      if (re_PC)
        sbq.push_back('{pc: pc_reg, data: pc_reg[15:0] ^ 16'hA001,
                        nxt: br_iss ? tgt : AW'(pc_reg + 18'd1)});
      if (instr_valid && prev_v && !prev_hs) chk("instr_stable", instr, prev_instr);
      if (instr_valid && instr_ready) begin
        if (sbq.size() == 0) chk("sb_unexpected_issue", 1, 0);
        else begin
          chk("sb_instr", instr, sbq[0].data);
          chk("sb_instr_pc", instr_pc, sbq[0].pc);
        end
      end
      if (wr_PC) begin
        if (sbq.size() == 0) chk("sb_unexpected_wr", 1, 0);
        else begin
          e = sbq.pop_front();
          chk("sb_pc_next", PC_next, e.nxt);
        end
      end
      prev_v = instr_valid;
      prev_hs = instr_valid && instr_ready;
      prev_instr = instr;
    end
  end

  task automatic wait_sig(input int which, input int lim, input string nm);
    bit hit = 0;
    for (int i = 0; i < lim && !hit; i++) begin
      @(negedge clk);
      case (which)
        0: hit = re_PC;
        1: hit = wr_PC;
        2: hit = mem_rd;
        default: hit = instr_valid;
      endcase
    end
    if (!hit) chk({nm, "_timeout"}, 0, 1);
  endtask

  task automatic do_reset(input logic [AW-1:0] pcv);
    run = 0; ack_en = 1; ack_force = 0; ack_dly = 0; rdy = 1; br_iss = 0; br_req = 0;
    pc_rst_val = pcv;
    @(negedge clk); rst = 1;
    @(negedge clk); @(negedge clk); rst = 0;
  endtask

  typedef struct {
    logic [AW-1:0] pc; bit biss; bit breq; logic [AW-1:0] tg; int dly;
    logic [AW-1:0] exp_next; logic [DW-1:0] exp_instr;
  } vec_t;
  vec_t vecs[6];

  initial begin
    int t0, n;
    bit saw;
    vecs[0] = '{18'h00000, 0, 0, 18'h00000, 0,  18'h00001, 16'hA001};
    vecs[1] = '{18'h3FFFF, 0, 0, 18'h00000, 0,  18'h00000, 16'h5FFE};
    vecs[2] = '{18'h00100, 1, 0, 18'h12345, 0,  18'h12345, 16'hA101};
    vecs[3] = '{18'h00200, 0, 1, 18'h12345, 0,  18'h00201, 16'hA201};
    vecs[4] = '{18'h00050, 0, 0, 18'h00000, 14, 18'h00051, 16'hA051};
    vecs[5] = '{18'h1ABCD, 0, 0, 18'h00000, 3,  18'h1ABCE, 16'h0BCC};

    // Reset state
    do_reset(18'h0);
    chk("rst_re_PC", re_PC, 0); chk("rst_wr_PC", wr_PC, 0); chk("rst_mem_rd", mem_rd, 0);
    chk("rst_valid", instr_valid, 0); chk("rst_fault", fault, 0);
    chk("rst_outs", {PC_next, mem_addr, instr, instr_pc}, 0);

    // Single fetches; run dropped mid-fetch so the block must park afterwards
    for (int v = 0; v < 6; v++) begin
      do_reset(vecs[v].pc);
      br_iss = vecs[v].biss; br_req = vecs[v].breq; tgt = vecs[v].tg; ack_dly = vecs[v].dly;
      run = 1;
      wait_sig(0, 10, "vec_re_PC");
      run = 0;
      wait_sig(1, 40, "vec_wr_PC");
      chk($sformatf("vec%0d_pc_next", v), PC_next, vecs[v].exp_next);
      chk($sformatf("vec%0d_instr", v), instr, vecs[v].exp_instr);
      chk($sformatf("vec%0d_instr_pc", v), instr_pc, vecs[v].pc);
      saw = 0;
      for (int i = 0; i < 4; i++) begin @(negedge clk); saw |= re_PC; end
      chk($sformatf("vec%0d_parked", v), saw, 0);
    end

    // Continuous fetch: loop latency and back-to-back re_PC
    do_reset(18'h0);
    run = 1;
    wait_sig(0, 10, "loop_re_PC");
    t0 = cyc;
    wait_sig(1, 20, "loop_wr_PC");
    chk("loop_latency", cyc - t0, 4);
    chk("loop_pc_next", PC_next, 18'h1);
    @(negedge clk);
    chk("loop_re_again", re_PC, 1);
    wait_sig(1, 20, "loop_wr2");
    chk("loop_pc_next2", PC_next, 18'h2);
    run = 0;
    repeat (3) @(negedge clk);

    // Downstream stall
    do_reset(18'h00777);
    rdy = 0; run = 1;
    wait_sig(3, 20, "stall_valid");
    run = 0;
    saw = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      saw |= wr_PC || !instr_valid;
    end
    chk("stall_hold", saw, 0);
    chk("stall_instr", instr, 16'hA776);
    rdy = 1;
    wait_sig(1, 5, "stall_wr");
    chk("stall_pc_next", PC_next, 18'h00778);

    // Memory timeout -> sticky fault
    do_reset(18'h00010);
    ack_en = 0; run = 1;
    wait_sig(2, 10, "tmo_mem_rd");
    n = 0;
    while (mem_rd && n < 100) begin n++; @(negedge clk); end
    chk("tmo_cycles", n, TO);
    chk("tmo_fault", fault, 1);
    ack_force = 1;
    saw = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      saw |= re_PC || wr_PC || mem_rd || instr_valid || !fault;
    end
    chk("tmo_sticky", saw, 0);
    do_reset(18'h0);
    chk("tmo_cleared", fault, 0);

    // Reset in the middle of REQ
    ack_en = 0; run = 1;
    wait_sig(2, 10, "mid_mem_rd");
    @(negedge clk); @(negedge clk);
    rst = 1; run = 0;
    @(negedge clk);
    chk("mid_strobes", {re_PC, wr_PC, mem_rd, instr_valid, fault}, 0);
    chk("mid_regs", {PC_next, mem_addr, instr, instr_pc}, 0);
    rst = 0; ack_en = 1;
    repeat (3) @(negedge clk);
    chk("mid_idle", {re_PC, mem_rd}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout reached");
    $fatal(1);
  end
endmodule
